// File: rtl/nibble_stream_pkg.sv
// Shared types and constants for the nibble stream serializer.
// Word layout is {lane3, lane2, lane1, lane0}; lane 3 bit 3 is the framing marker.
package nibble_stream_pkg;

  localparam int NUM_LANES  = 4;
  localparam int LANE_W     = 4;
  localparam int MARKER_BIT = LANE_W - 1;
  localparam int WORD_W     = NUM_LANES * LANE_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef logic [1:0]        lane_idx_t;
  typedef logic [WORD_W-1:0] word_t;

  function automatic logic [LANE_W-1:0] lane_sel(input word_t word, input lane_idx_t idx);
    return word[int'(idx)*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/nibble_lane_counter.sv
// 2-bit lane index with clear/enable; exposes next value so the top can register outputs.
// Clear has priority over enable; o_last flags the lane-3 slot.
module nibble_lane_counter
  import nibble_stream_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_clr,
  input  logic      i_en,
  output lane_idx_t o_cnt,
  output lane_idx_t o_cnt_nxt,
  output logic      o_last
);

  lane_idx_t r_cnt;
  lane_idx_t w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_en) begin
      w_cnt_nxt = r_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_last    = (r_cnt == 2'd3);

endmodule

// File: rtl/nibble_stream_serializer.sv
// Serializes a 4x4b marked word into four nibbles, lane 0 first; first nibble one cycle after accept.
// out_rdy low freezes the nibble; a new word is taken only in IDLE or on the lane-3 transfer edge.
module nibble_stream_serializer
  import nibble_stream_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [LANE_W-1:0] in0,
  input  logic [LANE_W-1:0] in1,
  input  logic [LANE_W-1:0] in2,
  input  logic [LANE_W-1:0] in3,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [LANE_W-1:0] out_data,
  output logic              out_last,
  output logic              err
);

  state_t            r_state;
  state_t            w_state_nxt;
  word_t             r_word;
  word_t             w_word_nxt;
  logic              r_out_val;
  logic [LANE_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_err;

  logic              w_in_rdy;
  logic              w_capture;
  logic              w_drop;
  logic              w_cnt_en;
  logic              w_last;
  lane_idx_t         w_cnt;
  lane_idx_t         w_cnt_nxt;

  nibble_lane_counter u_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_capture),
    .i_en      (w_cnt_en),
    .o_cnt     (w_cnt),
    .o_cnt_nxt (w_cnt_nxt),
    .o_last    (w_last)
  );

  // In SEND out_val is known high, so out_rdy alone marks a nibble transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    w_cnt_en    = 1'b0;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_rdy = 1'b1;
      end
      SEND: begin
        w_cnt_en = out_rdy & ~w_last;
        w_in_rdy = out_rdy & w_last;
        if (out_rdy && w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (reset) begin
      w_in_rdy = 1'b0;
    end
    w_capture = in_val & w_in_rdy & in3[MARKER_BIT];
    w_drop    = in_val & w_in_rdy & ~in3[MARKER_BIT];
    if (w_capture) begin
      w_state_nxt = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_word_nxt = w_capture ? {in3, in2, in1, in0} : r_word;

  // Outputs are registered from next-cycle state so they are stable for the whole cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word     <= '0;
      r_out_val  <= 1'b0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_word     <= w_word_nxt;
      r_out_val  <= (w_state_nxt == SEND);
      r_out_data <= (w_state_nxt == SEND) ? lane_sel(w_word_nxt, w_cnt_nxt) : '0;
      r_out_last <= (w_state_nxt == SEND) && (w_cnt_nxt == 2'd3);
      r_err      <= w_drop;
    end
  end

  assign in_rdy   = w_in_rdy;
  assign out_val  = r_out_val;
  assign out_data = r_out_data;
  assign out_last = r_out_last;
  assign err      = r_err;

endmodule

// File: tb/tb_nibble_stream_serializer.sv
// Per-cycle vector table for nibble_stream_serializer plus a hand-driven backpressure stream.
module tb_nibble_stream_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [3:0] in0, in1, in2, in3;
  logic       out_val;
  logic       out_rdy;
  logic [3:0] out_data;
  logic       out_last;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_stream_serializer dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_last (out_last),
    .err      (err)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] w;
    logic        ordy;
    logic        e_irdy;
    logic        e_oval;
    logic [3:0]  e_dat;
    logic        e_last;
    logic        e_err;
    logic        chk_dat;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic rst, input logic iv, input logic [15:0] w, input logic ordy,
                     input logic irdy, input logic oval, input logic [3:0] dat,
                     input logic last, input logic er, input logic chk);
    vec_t v;
    v.rst = rst; v.iv = iv; v.w = w; v.ordy = ordy;
    v.e_irdy = irdy; v.e_oval = oval; v.e_dat = dat;
    v.e_last = last; v.e_err = er; v.chk_dat = chk;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  logic [3:0] got_d [4];
  logic       got_l [4];
  logic [3:0] exp_n [4];
  int         n;

  initial begin
    reset = 1'b1; in_val = 1'b0; out_rdy = 1'b1;
    {in3, in2, in1, in0} = 16'h0;

    //   rst iv  word      ordy irdy oval dat   last err chk
    row(1, 0, 16'h0000, 1, 0, 0, 4'h0, 0, 0, 1);  // reset state
    row(0, 1, 16'hC321, 1, 1, 0, 4'h0, 0, 0, 0);  // accept word A
    row(0, 1, 16'hF765, 1, 0, 1, 4'h1, 0, 0, 1);
    row(0, 1, 16'hF765, 1, 0, 1, 4'h2, 0, 0, 1);
    row(0, 1, 16'hF765, 1, 0, 1, 4'h3, 0, 0, 1);
    row(0, 1, 16'hF765, 1, 1, 1, 4'hC, 1, 0, 1);  // lane-3 edge takes word B
    row(0, 0, 16'h0000, 1, 0, 1, 4'h5, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 0, 1, 4'h6, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 0, 1, 4'h7, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 1, 1, 4'hF, 1, 0, 1);
    row(0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 0, 0);
    row(0, 1, 16'hC321, 1, 1, 0, 4'h0, 0, 0, 0);  // backpressure run
    row(0, 0, 16'h0000, 1, 0, 1, 4'h1, 0, 0, 1);
    row(0, 0, 16'h0000, 0, 0, 1, 4'h2, 0, 0, 1);
    row(0, 0, 16'h0000, 0, 0, 1, 4'h2, 0, 0, 1);
    row(0, 0, 16'h0000, 0, 0, 1, 4'h2, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 0, 1, 4'h2, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 0, 1, 4'h3, 0, 0, 1);
    row(0, 1, 16'h8BA9, 0, 0, 1, 4'hC, 1, 0, 1);  // lane 3 stalled: in_rdy low
    row(0, 1, 16'h8BA9, 1, 1, 1, 4'hC, 1, 0, 1);
    row(0, 0, 16'h0000, 1, 0, 1, 4'h9, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 0, 1, 4'hA, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 0, 1, 4'hB, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 1, 1, 4'h8, 1, 0, 1);
    row(0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 0, 0);
    row(0, 1, 16'h4321, 1, 1, 0, 4'h0, 0, 0, 0);  // bad marker in IDLE
    row(0, 1, 16'h7321, 1, 1, 0, 4'h0, 0, 1, 0);
    row(0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 1, 0);
    row(0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 0, 0);
    row(0, 1, 16'h8FED, 1, 1, 0, 4'h0, 0, 0, 0);  // bad word on lane-3 edge
    row(0, 0, 16'h0000, 1, 0, 1, 4'hD, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 0, 1, 4'hE, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 0, 1, 4'hF, 0, 0, 1);
    row(0, 1, 16'h3321, 1, 1, 1, 4'h8, 1, 0, 1);
    row(0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 1, 0);
    row(0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 0, 0);
    row(0, 1, 16'hC321, 1, 1, 0, 4'h0, 0, 0, 0);  // reset mid-word
    row(0, 0, 16'h0000, 1, 0, 1, 4'h1, 0, 0, 1);
    row(1, 1, 16'hF765, 1, 0, 1, 4'h2, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 0, 1);
    row(0, 1, 16'hF765, 1, 1, 0, 4'h0, 0, 0, 0);
    row(0, 0, 16'h0000, 1, 0, 1, 4'h5, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 0, 1, 4'h6, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 0, 1, 4'h7, 0, 0, 1);
    row(0, 0, 16'h0000, 1, 1, 1, 4'hF, 1, 0, 1);
    row(0, 0, 16'h0000, 1, 1, 0, 4'h0, 0, 0, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset  = tbl[i].rst;
      in_val = tbl[i].iv;
      {in3, in2, in1, in0} = tbl[i].w;
      out_rdy = tbl[i].ordy;
      #1;
      chk($sformatf("row%0d in_rdy", i), {15'd0, in_rdy}, {15'd0, tbl[i].e_irdy});
      chk($sformatf("row%0d out_val", i), {15'd0, out_val}, {15'd0, tbl[i].e_oval});
      chk($sformatf("row%0d err", i), {15'd0, err}, {15'd0, tbl[i].e_err});
      if (tbl[i].chk_dat) begin
        chk($sformatf("row%0d out_data", i), {12'd0, out_data}, {12'd0, tbl[i].e_dat});
        chk($sformatf("row%0d out_last", i), {15'd0, out_last}, {15'd0, tbl[i].e_last});
      end
    end

    // Irregular out_rdy pattern: order and framing must survive stalls.
    exp_n[0] = 4'hA; exp_n[1] = 4'h5; exp_n[2] = 4'h0; exp_n[3] = 4'hF;
    for (int k = 0; k < 4; k++) begin
      got_d[k] = 4'h0;
      got_l[k] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0; in_val = 1'b1; out_rdy = 1'b0;
    {in3, in2, in1, in0} = 16'hF05A;
    #1;
    chk("hs in_rdy", {15'd0, in_rdy}, 16'd1);
    @(negedge clk);
    in_val = 1'b0;
    {in3, in2, in1, in0} = 16'h0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      out_rdy = (c % 3 == 0);
      #1;
      if (out_val && out_rdy) begin
        got_d[n] = out_data;
        got_l[n] = out_last;
        n++;
      end
      @(negedge clk);
    end
    #1;
    chk("hs nibble_count", n[15:0], 16'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hs data%0d", k), {12'd0, got_d[k]}, {12'd0, exp_n[k]});
      chk($sformatf("hs last%0d", k), {15'd0, got_l[k]}, {15'd0, (k == 3)});
    end
    chk("hs idle out_val", {15'd0, out_val}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
